ones_run_pattern_gen: RTL
=========================

# ones_run_pattern_gen

Serial stimulus transmitter for the consecutive-ones detector family. It accepts burst requests of the form "N ones, then M zeros" over a valid/ready handshake and drives them onto a one-bit serial line, one bit per clock. It also produces `exp_z`, a cycle-aligned prediction of the downstream detector's Mealy output: 1 on a 1-bit preceded by at least two consecutive 1s. It sits on the driving side of that detector, in benches and in on-chip self-test.

## Interface
Parameters:
- `LEN_W`, default 4: width of the run-length fields. Maximum run length is 2^LEN_W-1.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request offered.
- `req_ready`  out  1: request can be accepted this cycle.
- `req_ones`  in  LEN_W: number of 1 bits to emit.
- `req_zeros`  in  LEN_W: number of 0 bits that follow the ones.
- `x_out`  out  1: serial bit. Forced to 0 when idle.
- `bit_valid`  out  1: `x_out` carries a burst bit.
- `exp_z`  out  1: predicted detector output for the current `x_out`.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse after the final bit of a burst.

## Operation
- FSM states: IDLE, ONES, ZEROS. Counter `cnt` is LEN_W bits and holds the bits remaining in the current phase, minus 1.
- Accept occurs on a rising edge where `req_valid && req_ready`. The accepted request selects the next state:
  - `ones>0`: ONES, with `cnt = ones-1`.
  - `ones==0 && zeros>0`: ZEROS, with `cnt = zeros-1`.
  - both zero: IDLE, and `done` is set for the next cycle.
- ONES with `cnt==0` (end of ones phase):
  - `zeros>0`: go to ZEROS, `cnt = zeros-1`. The latched zeros length is used.
  - `zeros==0`: burst ends.
- ZEROS with `cnt==0`: burst ends.
- Burst end: if a request is accepted in the same cycle, start it per the accept rules. Otherwise go to IDLE. In both cases `done` is high the next cycle.
- Otherwise `cnt` decrements each cycle.
- `last_bit` = state is ONES or ZEROS, `cnt==0`, and no ZEROS phase follows.
- `req_ready = (state==IDLE) || last_bit`. This allows gapless back-to-back bursts.
- Combinational from state:
  - `x_out = (state==ONES)`
  - `bit_valid = (state!=IDLE)`
  - `busy = bit_valid`
- Request fields are captured at accept. Input changes after accept are ignored.
- Detector model:
  - 2-bit register `r` saturates at 2. Each cycle, `r <= x_out ? min(r+1,2) : 0`.
  - `exp_z = x_out && (r==2)`.
  - Idle cycles drive `x_out=0`, so they clear `r`, matching what the detector sees.
  - Gapless bursts with `zeros==0` concatenate their runs.
- Reset: state IDLE, `cnt=0`, `r=0`, `done=0`. Every output is 0 except `req_ready`, which is 1. A pending request is dropped.

## Timing
- Accept at edge t gives the first bit on cycles t..t+1 (visible the cycle after accept). Throughput is 1 bit/clk.
- A burst of N+M bits occupies exactly N+M cycles. `done` is high in the cycle after the last bit.
- A back-to-back accept on `last_bit` leaves zero idle cycles between bursts.
- `exp_z` is combinational on the registered `r` and state. It is valid in the same cycle as `x_out`.
- Reset assertion forces outputs to their reset values immediately, with no clock edge needed. Operation restarts in IDLE on the first edge after release.

## Structure
- Shared package `pattern_gen_pkg`:
  - state encoding: IDLE=2'b00, ONES=2'b01, ZEROS=2'b10
  - default `LEN_W`
  - `R_SAT=2`
- Sub-module `ones_run_model`: holds the `r` register and `exp_z` logic, with inputs `clk`, `rst`, `x`. It is reusable as a scoreboard reference against the detector.
- Unused state 2'b11 recovers to IDLE.

## Test plan
- Reset with `rst=0` → `x_out=0`, `bit_valid=0`, `exp_z=0`, `done=0`, `req_ready=1`. After release, still IDLE.
- Request (3,2) accepted at edge t → `x_out` is 1,1,1,0,0 on cycles t+1..t+5. `exp_z` is 1 only at t+3. `done` is 1 at t+6. `req_ready` is 1 at t+5.
- Request (2,0) followed immediately by (2,1), `req_valid` held → `x_out` is 1,1,1,1,0 with no gap. `exp_z` is 1 on the 3rd and 4th bits. `done` pulses after bit 2 and after bit 5.
- Request (0,0) → no `bit_valid`. `done` is 1 one cycle after accept. State remains IDLE with `req_ready=1`.
- `rst` dropped on the 2nd bit of (5,3) → outputs 0 asynchronously. After release, a new (1,1) request emits 1,0 with `exp_z=0`.
- Request (15,15) with `LEN_W=4` → 15 ones with `exp_z` high on the last 13 of them, then 15 zeros, then `done`.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// Shared constants for the consecutive-ones stimulus generator family:
// FSM encoding, default run-length width and the detector model saturation point.
package pattern_gen_pkg;

  localparam int DEFAULT_LEN_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ONES  = 2'b01;
  localparam logic [1:0] ST_ZEROS = 2'b10;

  localparam logic [1:0] R_SAT = 2'd2;

  // Next value of the detector's ones-run register: saturating count, cleared by a 0.
  function automatic logic [1:0] r_next(input logic x, input logic [1:0] r);
    if (!x) begin
      r_next = 2'd0;
    end else if (r >= R_SAT) begin
      r_next = R_SAT;
    end else begin
      r_next = r + 2'd1;
    end
  endfunction

endpackage

// File: rtl/ones_run_model.sv
// Reference model of the consecutive-ones Mealy detector: z is high on a 1
// that follows at least two consecutive 1s. Usable standalone as a scoreboard.
module ones_run_model
  import pattern_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic exp_z
);

  logic [1:0] r_r;

  // Ones-run history register, saturating at R_SAT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_r <= 2'd0;
    end else begin
      r_r <= r_next(x, r_r);
    end
  end

  assign exp_z = x && (r_r == R_SAT);

endmodule

// File: rtl/ones_run_pattern_gen.sv
// Serial burst transmitter: emits "N ones then M zeros" per accepted request,
// with gapless back-to-back bursts and a cycle-aligned detector prediction.
module ones_run_pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_ones,
  input  logic [LEN_W-1:0] req_zeros,
  output logic             x_out,
  output logic             bit_valid,
  output logic             exp_z,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_ZERO = LEN_W'(0);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] cnt_s;
  logic [LEN_W-1:0] zeros_r;
  logic [LEN_W-1:0] zeros_s;
  logic             done_r;
  logic             done_s;

  logic             last_bit_s;
  logic             accept_s;
  logic [1:0]       start_state_s;
  logic [LEN_W-1:0] start_cnt_s;
  logic             start_done_s;
  logic             x_s;

  assign x_s = (state_r == ST_ONES);

  // Final bit of the burst: the current phase ends and no zeros phase follows
  always_comb begin
    last_bit_s = 1'b0;
    case (state_r)
      ST_ONES:  last_bit_s = (cnt_r == CNT_ZERO) && (zeros_r == CNT_ZERO);
      ST_ZEROS: last_bit_s = (cnt_r == CNT_ZERO);
      default:  last_bit_s = 1'b0;
    endcase
  end

  assign req_ready = (state_r == ST_IDLE) || last_bit_s;
  assign accept_s  = req_valid && req_ready;

  // Where a freshly accepted request begins; an empty request completes at once
  always_comb begin
    start_state_s = ST_IDLE;
    start_cnt_s   = CNT_ZERO;
    start_done_s  = 1'b0;
    if (req_ones != CNT_ZERO) begin
      start_state_s = ST_ONES;
      start_cnt_s   = req_ones - CNT_ONE;
    end else if (req_zeros != CNT_ZERO) begin
      start_state_s = ST_ZEROS;
      start_cnt_s   = req_zeros - CNT_ONE;
    end else begin
      start_state_s = ST_IDLE;
      start_cnt_s   = CNT_ZERO;
      start_done_s  = 1'b1;
    end
  end

  // Next-state, phase counter, captured zeros length and done pulse
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    zeros_s = accept_s ? req_zeros : zeros_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = start_state_s;
          cnt_s   = start_cnt_s;
          done_s  = start_done_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ONES, ST_ZEROS: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if ((state_r == ST_ONES) && (zeros_r != CNT_ZERO)) begin
          // Ones phase rolls into the zeros phase of the same burst
          state_s = ST_ZEROS;
          cnt_s   = zeros_r - CNT_ONE;
        end else begin
          done_s = 1'b1;
          if (accept_s) begin
            state_s = start_state_s;
            cnt_s   = start_cnt_s;
          end else begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Generator state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      zeros_r <= CNT_ZERO;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      zeros_r <= zeros_s;
      done_r  <= done_s;
    end
  end

  assign x_out     = x_s;
  assign bit_valid = (state_r != ST_IDLE);
  assign busy      = bit_valid;
  assign done      = done_r;

  ones_run_model u_model (
    .clk   (clk),
    .rst   (rst),
    .x     (x_s),
    .exp_z (exp_z)
  );

endmodule
